// File: rtl/generic_bus_sram_responder_if.sv
// Generic bus between an initiator (cpu side) and a memory-side responder.
// The responder drives rdata/busy; the initiator drives the request fields.
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  modport generic_bus (
    input  addr,
    input  wdata,
    input  ren,
    input  wen,
    input  byte_en,
    output rdata,
    output busy
  );

  modport cpu (
    output addr,
    output wdata,
    output ren,
    output wen,
    output byte_en,
    input  rdata,
    input  busy
  );
endinterface

// File: rtl/generic_bus_sram_responder.sv
// Word-organised SRAM responder for the generic bus with programmable wait
// states, byte-lane writes and out-of-range flagging.
module generic_bus_sram_responder #(
  parameter int          WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ERR_DATA  = 32'hBAD1_BAD1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  generic_bus_if.generic_bus     bus_if,
  output logic                   err
);

  localparam int          DATA_W = 32;
  localparam int          AW     = $clog2(WORDS);
  localparam logic [32:0] SPAN   = 33'(WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LD = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [WORDS];

  logic              req;
  logic              commit;
  logic              hit;
  logic [AW-1:0]     idx;

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  // Low two bits of the offset select a byte within the word and are dropped.
  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  assign req    = bus_if.ren | bus_if.wen;
  assign hit    = addr_in_range(addr_q);
  assign idx    = word_index(addr_q);
  assign commit = (state == WAIT) && req && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT: begin
        if (!req)
          state_nxt = IDLE;
        else if (cnt == 4'd0)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, wait counter and registered status outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= commit && !hit;
      case (state)
        IDLE: begin
          if (req) begin
            cnt  <= CNT_LD;
            wr_q <= bus_if.wen;
          end
        end
        WAIT: begin
          if (req && cnt != 4'd0)
            cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
      if (commit && !wr_q)
        rdata_q <= hit ? mem[idx] : ERR_DATA;
    end
  end

  // Request capture: fields are sampled only when a request is accepted
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      addr_q  <= bus_if.addr;
      wdata_q <= bus_if.wdata;
      be_q    <= bus_if.byte_en;
    end
  end

  // Storage: commit is gated by state, so a reset before the DONE edge drops the write
  always_ff @(posedge CLK) begin
    if (commit && wr_q && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus_if.rdata = rdata_q;
  assign bus_if.busy  = (state != DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Scoreboard bench for generic_bus_sram_responder: one LATENCY=2 instance for
// the functional sequence and one LATENCY=1 instance for back-to-back reads.
module tb_generic_bus_sram_responder;

  logic clk;
  logic nrst;
  logic err_a;
  logic err_b;

  generic_bus_if ifa ();
  generic_bus_if ifb ();

  generic_bus_sram_responder #(
    .WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2), .ERR_DATA(32'hBAD1_BAD1)
  ) dut_a (
    .CLK(clk), .nRST(nrst), .bus_if(ifa), .err(err_a)
  );

  generic_bus_sram_responder #(
    .WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .ERR_DATA(32'hBAD1_BAD1)
  ) dut_b (
    .CLK(clk), .nRST(nrst), .bus_if(ifb), .err(err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitors: pop one expected entry per completion cycle
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      check("a_err_outside_done", 32'(err_a & ifa.busy), 32'd0);
      check("b_err_outside_done", 32'(err_b & ifb.busy), 32'd0);
      if (ifa.busy === 1'b0) begin
        checks++;
        if (qa.size() == 0) begin
          fails++;
          $display("FAIL a_unexpected_completion: busy 0 with nothing outstanding");
        end else begin
          e = qa.pop_front();
          check($sformatf("a_rdata_%0d", e.id), ifa.rdata, e.rdata);
          check($sformatf("a_err_%0d", e.id), 32'(err_a), 32'(e.err));
        end
      end
      if (ifb.busy === 1'b0) begin
        checks++;
        if (qb.size() == 0) begin
          fails++;
          $display("FAIL b_unexpected_completion: busy 0 with nothing outstanding");
        end else begin
          e = qb.pop_front();
          check($sformatf("b_rdata_%0d", e.id), ifb.rdata, e.rdata);
          check($sformatf("b_err_%0d", e.id), 32'(err_b), 32'(e.err));
        end
      end
    end
  end

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (s == 0) begin
      ifa.ren = r; ifa.wen = w; ifa.addr = a; ifa.wdata = d; ifa.byte_en = be;
    end else begin
      ifb.ren = r; ifb.wen = w; ifb.addr = a; ifb.wdata = d; ifb.byte_en = be;
    end
  endtask

  function automatic logic get_busy(input int s);
    return (s == 0) ? ifa.busy : ifb.busy;
  endfunction

  // Wait for busy to drop; returns cycles elapsed or -1 on timeout
  task automatic wait_done(input int s, output int n);
    bit done;
    done = 0;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (get_busy(s) == 1'b0) done = 1;
    end
    if (!done) n = -1;
  endtask

  task automatic access(input int s, input int id, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    e.rdata = exp_rd; e.err = exp_err; e.id = id;
    if (s == 0) qa.push_back(e); else qb.push_back(e);
    @(posedge clk); #1;
    drive(s, r, w, a, d, be);
    wait_done(s, n);
    check($sformatf("latency_%0d_%0d", s, id), 32'(n), 32'(lat + 1));
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    int   n;
    exp_t e;
    nrst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(ifa.busy), 32'd1);
      check("idle_rdata", ifa.rdata, 32'h0);
      check("idle_err", 32'(err_a), 32'd0);
    end

    access(0,  1, 0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0000_0000, 0, 2);
    access(0,  2, 1, 0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0, 2);
    access(0,  3, 0, 1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 0, 2);
    access(0,  4, 0, 1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 0, 2);
    access(0,  5, 1, 0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 0, 2);
    access(0,  6, 0, 1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h11BB33DD, 0, 2);
    access(0,  7, 0, 1, 32'h1000, 32'h12345678, 4'hF, 32'h11BB33DD, 1, 2);
    access(0,  8, 1, 0, 32'h1000, 32'h0,        4'hF, 32'hBAD1BAD1, 1, 2);
    access(0,  9, 1, 0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 0, 2);
    access(0, 10, 0, 1, 32'hFFC,  32'h0F0F0F0F, 4'hF, 32'hCAFEF00D, 0, 2);
    access(0, 11, 1, 0, 32'hFFE,  32'h0,        4'hF, 32'h0F0F0F0F, 0, 2);
    access(0, 12, 0, 1, 32'h30,   32'h30303030, 4'hF, 32'h0F0F0F0F, 0, 2);
    access(0, 13, 0, 1, 32'h10,   32'hAAAAAAAA, 4'h0, 32'h0F0F0F0F, 0, 2);
    access(0, 14, 1, 0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0, 2);

    // Abort: withdraw the write after one WAIT cycle
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) @(posedge clk);
    access(0, 15, 1, 0, 32'h30, 32'h0, 4'hF, 32'h30303030, 0, 2);

    // Asynchronous reset in the middle of a write
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h30, 32'h55555555, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #3;
    nrst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("rst_busy", 32'(ifa.busy), 32'd1);
    check("rst_rdata", ifa.rdata, 32'h0);
    check("rst_err", 32'(err_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    access(0, 16, 1, 0, 32'h30, 32'h0, 4'hF, 32'h30303030, 0, 2);

    // ren and wen together: performed as a write
    access(0, 17, 1, 1, 32'h40, 32'h44444444, 4'hF, 32'h30303030, 0, 2);
    access(0, 18, 1, 0, 32'h40, 32'h0,        4'hF, 32'h44444444, 0, 2);

    // Back-to-back reads with LATENCY=1
    access(1, 1, 0, 1, 32'h0, 32'h00000001, 4'hF, 32'h0, 0, 1);
    access(1, 2, 0, 1, 32'h4, 32'h00000002, 4'hF, 32'h0, 0, 1);
    e.rdata = 32'h1; e.err = 1'b0; e.id = 10;
    qb.push_back(e);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      wait_done(1, n);
      check($sformatf("b2b_period_%0d", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
      if (k < 5) begin
        e.rdata = ((k + 1) % 2 == 1) ? 32'h2 : 32'h1;
        e.id = 11 + k;
        qb.push_back(e);
        drive(1, 1'b1, 1'b0, ((k + 1) % 2 == 1) ? 32'h4 : 32'h0, 32'h0, 4'hF);
      end else begin
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end

    repeat (4) @(posedge clk);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/generic_bus_sram_responder.md
# generic_bus_sram_responder

Memory-side responder for the generic bus. It answers `ren`/`wen` requests from any generic-bus initiator, such as a cache, pass-through layer or arbiter, using an internal word-organised SRAM with a programmable number of wait states. It serves as the on-chip scratchpad and as the standard memory model behind the fetch and data paths in block-level benches. Byte enables are honoured on writes. Out-of-range accesses are flagged and never corrupt storage.

## Interface
- `WORDS`, 1024: number of 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `WORDS*4`.
- `LATENCY`, 2: wait-state cycles per access; legal range 1–15.
- `ERR_DATA`, 32'hBAD1_BAD1: `rdata` value returned for out-of-range reads.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `bus_if`  generic_bus_if.generic_bus  —  responder side of the generic bus:
  - `addr`  in  32  byte address
  - `wdata`  in  32  write data
  - `ren`  in  1  read request
  - `wen`  in  1  write request
  - `byte_en`  in  4  byte-lane enables
  - `rdata`  out  32  read data
  - `busy`  out  1  responder busy
- `err`  out  1  one-cycle pulse on completion of an out-of-range access.

## Operation
- The FSM has three states: IDLE, WAIT and DONE. It uses a 4-bit wait counter `cnt`.
- **IDLE**
  - `busy`=1.
  - If `ren|wen`: latch `addr`, `wdata`, `byte_en` and the op, where write has priority if both are high. Load `cnt`=`LATENCY-1` and go to WAIT.
- **WAIT**
  - `busy`=1.
  - If the initiator drops both `ren` and `wen`: abort, go to IDLE, no write, no `err`.
  - Else if `cnt`==0: go to DONE.
  - Else decrement `cnt`.
- **DONE**
  - `busy`=0 for exactly this one cycle, then go to IDLE.
- **Range check**
  - In range means `BASE_ADDR <= addr < BASE_ADDR + WORDS*4`.
  - Word index is `(addr-BASE_ADDR)[log2(WORDS)+1:2]`. `addr[1:0]` is ignored.
- **Read**
  - On the WAIT→DONE edge, `rdata` is loaded from the SRAM word.
  - For an out-of-range read, `rdata` is loaded with `ERR_DATA` instead.
  - `rdata` holds until the next read completion. Writes leave `rdata` unchanged.
- **Write**
  - On the WAIT→DONE edge, each lane i with `byte_en[i]`=1 writes `wdata[8i+7:8i]`.
  - Lanes with enable 0 are unchanged.
  - `byte_en`=0000 completes normally without modifying storage.
  - Out-of-range writes are dropped.
- **err**
  - `err` is 1 during DONE of an out-of-range access, otherwise 0.
- **Request changes**
  - Changes to `addr`, `wdata` or `byte_en` during WAIT are ignored; latched values are used.
  - The initiator must hold its request until `busy`=0; the abort path covers withdrawal.
- **Reset values**
  - State=IDLE, `cnt`=0, `busy`=1, `rdata`=0, `err`=0.
  - SRAM contents are not reset. They are undefined until written and are preserved across `nRST`.

## Timing
- Request present in cycle 0 (IDLE) → WAIT in cycles 1..`LATENCY` → DONE in cycle `LATENCY`+1, with `busy`=0 and `rdata` valid.
- Total latency is `LATENCY`+1 cycles from request to completion.
- After DONE, at least one IDLE cycle follows. A request held continuously is accepted in that IDLE cycle, so the back-to-back throughput is one access per `LATENCY`+2 cycles.
- Write data is visible to a read accepted in the very next IDLE cycle; there is no read-after-write hazard.
- `nRST` assertion in any state forces IDLE immediately, without waiting for an edge. An in-flight write whose DONE edge has not occurred is not committed.
- Only `rdata`, `busy` and `err` are outputs; all are registered or decoded from state. No input→output combinational path exists.

## Test plan
- **Reset/idle:** after `nRST` release with no request → `busy`=1, `rdata`=0, `err`=0, held for ≥20 cycles.
- **Write then read, `LATENCY`=2:**
  - Write 32'hDEADBEEF to 0x10 with `byte_en`=1111 → `busy` low only in cycle 3.
  - Then read 0x10 → `busy` low in cycle 3 with `rdata`=DEADBEEF.
- **Byte lanes:**
  - Write 0x11223344 to 0x20 with 1111.
  - Then write 0xAABBCCDD with `byte_en`=0101.
  - Then read 0x20 → 0x11BB33DD.
- **Out of range, `WORDS`=1024, `BASE_ADDR`=0:**
  - Write to 0x1000, then read 0x1000 → `err` pulses in each DONE and `rdata`=BAD1BAD1.
  - Read 0x0 afterwards → prior contents intact.
- **Abort and reset mid-op:**
  - Drop `wen` in cycle 1 of a write to 0x30 → IDLE, no `busy`=0 pulse, and a subsequent read shows the old value.
  - Assert `nRST` during WAIT of a write → write not committed, outputs at reset values.
- **Back-to-back and priority:**
  - Hold `ren` continuously on alternating addresses with `LATENCY`=1 → a completion every 3 cycles.
  - Assert `ren`=`wen`=1 → the access is performed as a write.
